// File: rtl/regfile_dump_pkg.sv
// Shared types and sizes for the register-file debug dump engine.
package regfile_dump_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int REG_ADDR_W     = 5;
  localparam int DATA_W         = 32;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_beat_t;
endpackage

// File: rtl/regfile_dump_word_serializer.sv
// Holds one captured register word and presents it LSB byte first;
// the byte index only moves on an accepted transfer.
module word_serializer
  import regfile_dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  input  logic              adv,
  output byte_beat_t        beat
);
  logic [DATA_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      word_q <= word_in;
      cnt_q  <= '0;
    end else if (adv && cnt_q != LAST_BYTE) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign beat.data = word_q[{cnt_q, 3'b000} +: 8];
  assign beat.last = (cnt_q == LAST_BYTE);
endmodule

// File: rtl/regfile_dump.sv
// Walks registers FIRST..LAST through one read port and streams each
// snapshot out as little-endian bytes on a valid/ready byte interface.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned FIRST = 0,
  parameter int unsigned LAST  = 31
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0]     rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST);

  state_t                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   idx_q, idx_d;
  byte_beat_t              beat;
  logic                    adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:    if (start && !abort) begin
                 idx_d   = FIRST_IDX;
                 state_d = CAPTURE;
               end
      CAPTURE: state_d = SEND;
      SEND:    if (out_ready && beat.last) begin
                 if (idx_q == LAST_IDX) state_d = DONE;
                 else begin
                   idx_d   = idx_q + 1'b1;
                   state_d = CAPTURE;
                 end
               end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort beats any same-cycle transfer: the byte is treated as unsent
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      idx_d   = idx_q;
    end
  end

  assign adv = (state_q == SEND) && out_ready && !abort;

  word_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q == CAPTURE),
    .word_in (rdata),
    .adv     (adv),
    .beat    (beat)
  );

  assign rs        = idx_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? beat.data : '0;
  assign out_last  = out_valid && beat.last && (idx_q == LAST_IDX);
  assign busy      = (state_q == CAPTURE) || (state_q == SEND);
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: full dump, stalls, snapshot, abort, reset.
module tb_regfile_dump;
  import regfile_dump_pkg::*;
  localparam int FIRST = 0, LAST = 31;

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [4:0] rs;  logic [31:0] rdata;
  logic out_valid, out_last, busy, done;  logic [7:0] out_data;
  logic start5 = 1'b0, abort5 = 1'b0, out_ready5 = 1'b0;
  logic [4:0] rs5; logic [31:0] rdata5;
  logic out_valid5, out_last5, busy5, done5; logic [7:0] out_data5;

  logic [31:0] regs [32];
  assign rdata  = regs[rs];
  assign rdata5 = regs[rs5];

  always #5 clk = ~clk;

  regfile_dump #(.FIRST(FIRST), .LAST(LAST)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rs(rs), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done));

  regfile_dump #(.FIRST(5), .LAST(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .abort(abort5), .rs(rs5), .rdata(rdata5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .out_last(out_last5), .busy(busy5), .done(done5));

  int n_chk = 0, n_pass = 0, cyc = 0;
  int nbytes = 0, nlast = 0, done_cnt = 0, busy_cyc = 0, start_cyc = 0, done_cyc = 0;
  int nbytes5 = 0, nlast5 = 0, done5_cnt = 0, last5_idx = -1;
  byte_beat_t sb [$];
  byte_beat_t e_a;
  logic [7:0] blog [$];
  logic [7:0] blog5 [$];
  logic pstall = 1'b0, pstall5 = 1'b0, plast = 1'b0;
  logic [7:0] pdata = '0, pdata5 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // main DUT monitor: scoreboard pop on each accepted byte, stall stability
  always @(negedge clk) begin
    if (rst) pstall = 1'b0;
    else begin
      if (pstall) begin
        chk("stall_data", 32'(out_data), 32'(pdata));
        chk("stall_last", 32'(out_last), 32'(plast));
      end
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid && out_ready && !abort) begin
        nbytes++;
        blog.push_back(out_data);
        if (out_last) nlast++;
        e_a = 'x;
        if (sb.size() != 0) e_a = sb.pop_front();
        chk("byte", 32'(out_data), 32'(e_a.data));
        chk("last", 32'(out_last), 32'(e_a.last));
      end
      pstall = out_valid && !out_ready && !abort;
      pdata  = out_data;
      plast  = out_last;
    end
  end

  always @(negedge clk) begin
    if (rst) pstall5 = 1'b0;
    else begin
      if (pstall5) chk("stall5_data", 32'(out_data5), 32'(pdata5));
      if (done5) done5_cnt++;
      if (out_valid5 && out_ready5) begin
        nbytes5++;
        blog5.push_back(out_data5);
        if (out_last5) begin nlast5++; last5_idx = blog5.size() - 1; end
      end
      pstall5 = out_valid5 && !out_ready5;
      pdata5  = out_data5;
    end
  end

  task automatic start_dump();
    sb.delete(); blog.delete();
    nbytes = 0; nlast = 0; busy_cyc = 0;
    for (int r = FIRST; r <= LAST; r++)
      for (int b = 0; b < 4; b++)
        sb.push_back('{data: regs[r][8*b +: 8], last: (r == LAST && b == 3)});
    start = 1'b1; tick(); start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    while (done_cnt < target && k < 500) begin tick(); k++; end
    chk(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_rs_valid(input int r, input string tag);
    int k = 0;
    while (!(rs == 5'(r) && out_valid) && k < 300) begin tick(); k++; end
    chk(tag, 32'(rs), 32'(r));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 32'h11223344; regs[2] = 32'h1; regs[31] = 32'hDEADBEEF;
    regs[5] = 32'hA5A55A5A;
    repeat (3) tick();
    chk("rst_rs", 32'(rs), 0);          chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);  chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);      chk("rst_done", 32'(done), 0);
    rst = 1'b0; out_ready = 1'b1;
    tick();

    // full-rate dump, snapshot write to x2 mid-send, start while busy
    start_dump();
    wait_rs_valid(2, "reach_x2");
    regs[2] = 32'hCAFEF00D;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(1, "done1");
    chk("latency", 32'(done_cyc - start_cyc), 160);
    chk("busy_cycles", 32'(busy_cyc), 160);
    chk("nbytes1", 32'(nbytes), 128);
    chk("nlast1", 32'(nlast), 1);
    chk("sb_left1", 32'(sb.size()), 0);
    chk("b4", 32'(blog[4]), 32'h44);   chk("b5", 32'(blog[5]), 32'h33);
    chk("b6", 32'(blog[6]), 32'h22);   chk("b7", 32'(blog[7]), 32'h11);
    chk("b8_snap", 32'(blog[8]), 32'h01); chk("b9_snap", 32'(blog[9]), 32'h00);
    chk("b124", 32'(blog[124]), 32'hEF); chk("b125", 32'(blog[125]), 32'hBE);
    chk("b126", 32'(blog[126]), 32'hAD); chk("b127", 32'(blog[127]), 32'hDE);
    repeat (3) tick();
    chk("idle_after1", 32'(busy), 0);

    // second dump sees the new x2 value
    start_dump();
    wait_done(2, "done2");
    chk("nbytes2", 32'(nbytes), 128);
    chk("b8_new", 32'(blog[8]), 32'h0D);  chk("b11_new", 32'(blog[11]), 32'hCA);
    repeat (2) tick();

    // abort mid-register 10 while stalled
    start_dump();
    wait_rs_valid(10, "reach_x10");
    tick();
    out_ready = 1'b0; tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    sb.delete();
    repeat (3) tick();
    chk("abort_no_done", 32'(done_cnt), 2);
    out_ready = 1'b1;
    start_dump();
    wait_done(3, "done3");
    chk("nbytes3", 32'(nbytes), 128);
    chk("restart_b4", 32'(blog[4]), 32'h44);
    chk("sb_left3", 32'(sb.size()), 0);
    repeat (2) tick();

    // reset during SEND
    start_dump();
    repeat (7) tick();
    rst = 1'b1; tick();
    chk("mrst_rs", 32'(rs), 0);          chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);  chk("mrst_last", 32'(out_last), 0);
    chk("mrst_busy", 32'(busy), 0);      chk("mrst_done", 32'(done), 0);
    rst = 1'b0; sb.delete();
    tick();

    // start and abort together in idle
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    repeat (3) tick();
    chk("sa_busy_later", 32'(busy), 0);
    chk("sa_valid", 32'(out_valid), 0);
    chk("sa_no_done", 32'(done_cnt), 3);

    // single-register instance with out_ready toggling every cycle
    start5 = 1'b1; tick(); start5 = 1'b0;
    for (int k = 0; k < 100 && done5_cnt < 1; k++) begin
      out_ready5 = ~out_ready5; tick();
    end
    repeat (4) tick();
    chk("d5_once", 32'(done5_cnt), 1);
    chk("d5_nbytes", 32'(nbytes5), 4);
    chk("d5_b0", 32'(blog5[0]), 32'h5A); chk("d5_b1", 32'(blog5[1]), 32'h5A);
    chk("d5_b2", 32'(blog5[2]), 32'hA5); chk("d5_b3", 32'(blog5[3]), 32'hA5);
    chk("d5_last_at", 32'(last5_idx), 3);
    chk("d5_nlast", 32'(nlast5), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
